vga_sync_gen: RTL and testbench

Video timing generator that produces the horizontal and vertical pixel counters consumed by the video cores (bar, color, sprite generators), along with the VGA sync and display-enable signals. It derives a pixel-rate tick from the system clock and counts pixels and lines through display, front porch, sync and back porch. It also supplies delayed copies of the sync and display-enable signals, so they align with RGB produced by pipelined video cores.

---
 rtl/vga_sync_gen_pkg.sv | 22 ++
 rtl/vga_sync_gen_delay_line.sv | 26 ++
 rtl/vga_sync_gen.sv | 74 +++++++
 tb/tb_vga_sync_gen.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/vga_sync_gen_pkg.sv
// vga_sync_gen_pkg: default VGA timing constants, counter widths and the sync bundle type.
package vga_sync_gen_pkg;
  localparam int DEF_H_DISPLAY = 640;
  localparam int DEF_H_FRONT = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BACK = 48;
  localparam int DEF_V_DISPLAY = 480;
  localparam int DEF_V_FRONT = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BACK = 33;
  localparam int H_SIZE = 10;
  localparam int V_SIZE = 10;
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic video_on;
  } sync_t;
  localparam sync_t SYNC_RST = '{hsync: 1'b1, vsync: 1'b1, video_on: 1'b0};
  function automatic logic in_win(int v, int lo, int n);
    return v >= lo && v < lo + n;
  endfunction
endpackage

// File: rtl/vga_sync_gen_delay_line.sv
// vga_delay_line: D-stage shift register with a loadable reset value; D = 0 is a wire.
module vga_delay_line #(
  parameter int W = 1,
  parameter int D = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_rst_val,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  if (D == 0) begin : g_pass
    assign o_q = i_d;
  end else begin : g_sr
    logic [W-1:0] r_sr [D];
    always_ff @(posedge clk) begin
      if (!rst) begin
        for (int i = 0; i < D; i++) r_sr[i] <= i_rst_val;
      end else begin
        r_sr[0] <= i_d;
        for (int i = 1; i < D; i++) r_sr[i] <= r_sr[i-1];
      end
    end
    assign o_q = r_sr[D-1];
  end
endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: pixel-tick divider, h/v counters, sync/video decode and delayed sync outputs.
module vga_sync_gen
  import vga_sync_gen_pkg::*;
#(
  parameter int H_DISPLAY = DEF_H_DISPLAY,
  parameter int H_FRONT = DEF_H_FRONT,
  parameter int H_SYNC = DEF_H_SYNC,
  parameter int H_BACK = DEF_H_BACK,
  parameter int V_DISPLAY = DEF_V_DISPLAY,
  parameter int V_FRONT = DEF_V_FRONT,
  parameter int V_SYNC = DEF_V_SYNC,
  parameter int V_BACK = DEF_V_BACK,
  parameter int CLK_DIV = 2,
  parameter int DLY = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic [H_SIZE-1:0] hc,
  output logic [V_SIZE-1:0] vc,
  output logic              pixel_tick,
  output logic              video_on,
  output logic              frame_start,
  output logic              hsync_o,
  output logic              vsync_o,
  output logic              video_on_o
);
  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  logic [3:0] r_tick_cnt;
  logic [H_SIZE-1:0] r_hc, w_hc_nxt;
  logic [V_SIZE-1:0] r_vc, w_vc_nxt;
  logic r_frame_start, w_h_wrap, w_v_end;
  sync_t r_sync, w_sync, w_dly;
  always_comb begin
    pixel_tick = r_tick_cnt == 4'(CLK_DIV - 1);
    w_h_wrap = pixel_tick && r_hc == H_SIZE'(H_TOTAL - 1);
    w_v_end = r_vc == V_SIZE'(V_TOTAL - 1);
    w_hc_nxt = !pixel_tick ? r_hc : w_h_wrap ? '0 : r_hc + 1'b1;
    w_vc_nxt = !w_h_wrap ? r_vc : w_v_end ? '0 : r_vc + 1'b1;
    // Decode from next-state counters so the registered flags line up with hc/vc.
    w_sync.hsync = !in_win(int'(w_hc_nxt), H_DISPLAY + H_FRONT, H_SYNC);
    w_sync.vsync = !in_win(int'(w_vc_nxt), V_DISPLAY + V_FRONT, V_SYNC);
    w_sync.video_on = int'(w_hc_nxt) < H_DISPLAY && int'(w_vc_nxt) < V_DISPLAY;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_tick_cnt <= '0;
      r_hc <= '0;
      r_vc <= '0;
      r_frame_start <= 1'b0;
      r_sync <= SYNC_RST;
    end else begin
      r_tick_cnt <= pixel_tick ? '0 : r_tick_cnt + 1'b1;
      r_hc <= w_hc_nxt;
      r_vc <= w_vc_nxt;
      r_frame_start <= w_h_wrap && w_v_end;
      r_sync <= w_sync;
    end
  end
  vga_delay_line #(.W(3), .D(DLY)) u_dly (
    .clk(clk),
    .rst(rst),
    .i_rst_val(SYNC_RST),
    .i_d(r_sync),
    .o_q(w_dly)
  );
  assign hc = r_hc;
  assign vc = r_vc;
  assign video_on = r_sync.video_on;
  assign frame_start = r_frame_start;
  assign hsync_o = w_dly.hsync;
  assign vsync_o = w_dly.vsync;
  assign video_on_o = w_dly.video_on;
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: directed checks of default timing, DLY=2 vs DLY=0 skew, and a short-frame variant.
module tb_vga_sync_gen;
  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;
  logic [9:0] a_hc, a_vc, z_hc, z_vc, s_hc, s_vc;
  logic a_pt, a_von, a_fs, a_hs, a_vs, a_vo;
  logic z_pt, z_von, z_fs, z_hs, z_vs, z_vo;
  logic s_pt, s_von, s_fs, s_hs, s_vs, s_vo;
  vga_sync_gen u_dut (.clk(clk), .rst(rst), .hc(a_hc), .vc(a_vc), .pixel_tick(a_pt),
    .video_on(a_von), .frame_start(a_fs), .hsync_o(a_hs), .vsync_o(a_vs), .video_on_o(a_vo));
  vga_sync_gen #(.DLY(0)) u_d0 (.clk(clk), .rst(rst), .hc(z_hc), .vc(z_vc), .pixel_tick(z_pt),
    .video_on(z_von), .frame_start(z_fs), .hsync_o(z_hs), .vsync_o(z_vs), .video_on_o(z_vo));
  vga_sync_gen #(.V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .CLK_DIV(1), .DLY(0)) u_sm (
    .clk(clk), .rst(rst), .hc(s_hc), .vc(s_vc), .pixel_tick(s_pt),
    .video_on(s_von), .frame_start(s_fs), .hsync_o(s_hs), .vsync_o(s_vs), .video_on_o(s_vo));
  int total = 0, bad = 0, k = 0;
  logic [2:0] hist [0:2200];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    @(negedge clk);
    k++;
  endtask
  task automatic chk_rst(input string tag);
    chk({tag, "_hc"}, 32'(a_hc), 0);
    chk({tag, "_vc"}, 32'(a_vc), 0);
    chk({tag, "_von"}, 32'(a_von), 0);
    chk({tag, "_fs"}, 32'(a_fs), 0);
    chk({tag, "_pt"}, 32'(a_pt), 0);
    chk({tag, "_hs_o"}, 32'(a_hs), 1);
    chk({tag, "_vs_o"}, 32'(a_vs), 1);
    chk({tag, "_vo_o"}, 32'(a_vo), 0);
    chk({tag, "_sm_hc"}, 32'(s_hc), 0);
  endtask
  initial begin
    int ticks = 0, hs_lo = 0, hs_first = -1, hs_last = -1, von_lo = 0, von_first = -1;
    int vs_lo = 0, dly_err = 0, a_fs_n = 0, s_fs_n = 0, s_fs_k = -1, s_vs_lo = 0;
    int s_vs_min = 99, s_vs_max = -1, s_pt_lo = 0;
    rst = 1'b0;
    repeat (5) step;
    chk_rst("reset");
    rst = 1'b1;
    k = 0;
    for (int n = 0; n < 2200; n++) begin
      step;
      hist[k] = {z_hs, z_vs, z_vo};
      if (k >= 3 && {a_hs, a_vs, a_vo} !== hist[k-2]) dly_err++;
      if (k <= 1600) begin
        ticks += int'(a_pt);
        if (!z_hs) begin
          hs_lo++;
          if (hs_first < 0) hs_first = int'(z_hc);
          hs_last = int'(z_hc);
        end
        if (!a_von) begin
          von_lo++;
          if (von_first < 0) von_first = int'(a_hc);
        end
      end
      if (!z_vs) vs_lo++;
      if (k == 1) begin
        chk("von_after_release", 32'(a_von), 1);
        chk("pt_k1", 32'(a_pt), 1);
        chk("vo_o_k1_still_rst", 32'(a_vo), 0);
      end
      if (k == 2) begin
        chk("pt_k2", 32'(a_pt), 0);
        chk("hc_k2", 32'(a_hc), 1);
      end
      if (k == 3) chk("vo_o_k3", 32'(a_vo), 1);
      if (k == 1311) chk("z_hs_k1311", 32'(z_hs), 1);
      if (k == 1312) begin
        chk("z_hs_k1312", 32'(z_hs), 0);
        chk("a_hs_k1312", 32'(a_hs), 1);
      end
      if (k == 1314) chk("a_hs_k1314", 32'(a_hs), 0);
      if (k == 1598) begin
        chk("hc_799", 32'(a_hc), 799);
        chk("vc_before_wrap", 32'(a_vc), 0);
      end
      if (k == 1600) begin
        chk("hc_wrap", 32'(a_hc), 0);
        chk("vc_inc", 32'(a_vc), 1);
      end
    end
    chk("ticks_per_line", 32'(ticks), 800);
    chk("hs_lo_clks", 32'(hs_lo), 192);
    chk("hs_first_hc", 32'(hs_first), 656);
    chk("hs_last_hc", 32'(hs_last), 751);
    chk("von_lo_clks", 32'(von_lo), 320);
    chk("von_first_lo_hc", 32'(von_first), 640);
    chk("vs_lo_lines01", 32'(vs_lo), 0);
    chk("dly2_vs_dly0", 32'(dly_err), 0);
    chk("mid_hc", 32'(a_hc), 300);
    chk("mid_vc", 32'(a_vc), 1);
    rst = 1'b0;
    step;
    chk_rst("mid_rst");
    step;
    rst = 1'b1;
    k = 0;
    for (int n = 0; n < 6500; n++) begin
      step;
      a_fs_n += int'(a_fs);
      if (s_fs) begin
        s_fs_n++;
        s_fs_k = k;
      end
      if (!s_pt) s_pt_lo++;
      if (!s_vs) begin
        s_vs_lo++;
        if (int'(s_vc) < s_vs_min) s_vs_min = int'(s_vc);
        if (int'(s_vc) > s_vs_max) s_vs_max = int'(s_vc);
      end
      if (k == 2) chk("restart_hc", 32'(a_hc), 1);
      if (k == 6399) begin
        chk("sm_hc_end", 32'(s_hc), 799);
        chk("sm_vc_end", 32'(s_vc), 7);
      end
      if (k == 6400) begin
        chk("sm_hc_wrap", 32'(s_hc), 0);
        chk("sm_vc_wrap", 32'(s_vc), 0);
      end
    end
    chk("no_fs_after_release", 32'(a_fs_n), 0);
    chk("sm_fs_count", 32'(s_fs_n), 1);
    chk("sm_fs_clk", 32'(s_fs_k), 6400);
    chk("sm_pt_always", 32'(s_pt_lo), 0);
    chk("sm_vs_lo_clks", 32'(s_vs_lo), 1600);
    chk("sm_vs_min_vc", 32'(s_vs_min), 5);
    chk("sm_vs_max_vc", 32'(s_vs_max), 6);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
